// File: rtl/sa_ctrl.sv
// Sequencer for an N x N systolic array: issues skewed operand-buffer reads,
// drives the top-left PE calibration strobes and counts results out of the bottom row.
module sa_ctrl #(
  parameter int N     = 4,
  parameter int K_W   = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [K_W-1:0]     k_len,
  output logic               busy,
  output logic               done,
  output logic               cal_en,
  output logic               cal_done,
  output logic [N-1:0]       a_rd_en,
  output logic [N*K_W-1:0]   a_rd_addr,
  output logic [N-1:0]       b_rd_en,
  output logic [N*K_W-1:0]   b_rd_addr,
  input  logic [N-1:0]       res_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] NN_C = CNT_W'(N * N);

  state_t             state_r, state_s;
  logic [K_W-1:0]     t_r, t_s;
  logic [K_W-1:0]     kreg_r, kreg_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CNT_W-1:0]   acc_s;
  logic [CNT_W:0]     sum_s;
  logic               base_en_s;
  logic [K_W-1:0]     base_addr_s;
  logic [N-1:0]       en_pipe_r;
  logic [K_W-1:0]     addr_pipe_r [N];

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = {CNT_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

  // Result counter candidate: saturating add of this cycle's bottom-row strobes
  always_comb begin
    sum_s = {1'b0, cnt_r} + {1'b0, popcount(res_val)};
    if (sum_s[CNT_W]) begin
      acc_s = {CNT_W{1'b1}};
    end else begin
      acc_s = sum_s[CNT_W-1:0];
    end
  end

  // Next-state, cycle counter and base read strobe
  always_comb begin
    state_s     = state_r;
    t_s         = t_r;
    kreg_s      = kreg_r;
    cnt_s       = cnt_r;
    base_en_s   = 1'b0;
    base_addr_s = {K_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          if (k_len != {K_W{1'b0}}) begin
            state_s   = RUN;
            kreg_s    = k_len;
            t_s       = {K_W{1'b0}};
            base_en_s = 1'b1;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        cnt_s = acc_s;
        if (t_r == kreg_r) begin
          state_s = DRAIN;
        end else begin
          t_s = t_r + {{(K_W-1){1'b0}}, 1'b1};
          // The final RUN cycle (t == kreg) issues no read, so the PE product there is zero
          if (t_s < kreg_r) begin
            base_en_s   = 1'b1;
            base_addr_s = t_s;
          end else begin
            base_en_s = 1'b0;
          end
        end
      end
      DRAIN: begin
        cnt_s = acc_s;
        if (acc_s >= NN_C) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        t_s     = {K_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, skew chain and registered outputs
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r   <= IDLE;
      t_r       <= {K_W{1'b0}};
      kreg_r    <= {K_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      cal_en    <= 1'b0;
      cal_done  <= 1'b0;
      en_pipe_r <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        addr_pipe_r[i] <= {K_W{1'b0}};
      end
    end else begin
      state_r  <= state_s;
      t_r      <= t_s;
      kreg_r   <= kreg_s;
      cnt_r    <= cnt_s;
      busy     <= (state_s != IDLE);
      done     <= (state_s == DONE);
      cal_en   <= (state_s == RUN);
      cal_done <= (state_s == RUN) && (t_s == kreg_s);
      if ((state_s == RUN) || (state_s == DRAIN)) begin
        en_pipe_r[0]   <= base_en_s;
        addr_pipe_r[0] <= base_addr_s;
        for (int i = 1; i < N; i++) begin
          en_pipe_r[i]   <= en_pipe_r[i-1];
          addr_pipe_r[i] <= addr_pipe_r[i-1];
        end
      end else begin
        en_pipe_r <= {N{1'b0}};
        for (int i = 0; i < N; i++) begin
          addr_pipe_r[i] <= {K_W{1'b0}};
        end
      end
    end
  end

  // Row and column buffers share one skew chain
  always_comb begin
    a_rd_en   = en_pipe_r;
    b_rd_en   = en_pipe_r;
    a_rd_addr = {(N*K_W){1'b0}};
    b_rd_addr = {(N*K_W){1'b0}};
    for (int i = 0; i < N; i++) begin
      a_rd_addr[i*K_W +: K_W] = addr_pipe_r[i];
      b_rd_addr[i*K_W +: K_W] = addr_pipe_r[i];
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// Scoreboard bench for sa_ctrl (N=4, K_W=8): per-cycle expected output vectors
// are queued when a job is launched and compared as the DUT advances.
module tb_sa_ctrl;

  localparam int N = 4;
  localparam int K_W = 8;
  localparam int CNT_W = 8;
  localparam int VW = 4 + 2 * N + 2 * N * K_W;

  logic               clk;
  logic               sys_rst;
  logic               start;
  logic [K_W-1:0]     k_len;
  logic               busy, done, cal_en, cal_done;
  logic [N-1:0]       a_rd_en, b_rd_en;
  logic [N*K_W-1:0]   a_rd_addr, b_rd_addr;
  logic [N-1:0]       res_val;
  logic [VW-1:0]      obs_s;

  logic [N-1:0]       sched [0:63];
  logic [VW-1:0]      exp_q [$];
  int                 n_cmp;
  int                 n_err;

  sa_ctrl #(.N(N), .K_W(K_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .cal_en    (cal_en),
    .cal_done  (cal_done),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr),
    .res_val   (res_val)
  );

  assign obs_s = {busy, done, cal_en, cal_done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr};

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Expected outputs c cycles after the start cycle; dc = done cycle, rc = reset cycle (-1 none)
  function automatic logic [VW-1:0] exp_vec(input int c, input int k, input int dc, input int rc);
    logic [N-1:0]     en;
    logic [N*K_W-1:0] ad;
    logic             b, d, ce, cd;
    en = '0;
    ad = '0;
    if (rc >= 0 && c > rc) return '0;
    b  = (c >= 1 && c <= dc);
    d  = (c == dc);
    ce = (k != 0 && c >= 1 && c <= k + 1);
    cd = (k != 0 && c == k + 1);
    for (int i = 0; i < N; i++) begin
      if (k != 0 && c >= 1 + i && c <= k + i) begin
        en[i] = 1'b1;
        ad[i*K_W +: K_W] = K_W'(c - 1 - i);
      end
    end
    return {b, d, ce, cd, en, en, ad, ad};
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) sched[i] = '0;
  endtask

  task automatic run_job(input string nm, input int k, input int ncyc,
                         input int rs_c, input int rs_k, input int rst_c);
    int dc;
    int cum;
    logic [VW-1:0] e;
    if (k == 0) begin
      dc = 1;
    end else begin
      dc = 1000;
      cum = 0;
      for (int c = 1; c <= ncyc; c++) begin
        cum += $countones(sched[c]);
        if (cum >= N * N) begin
          dc = c + 1;
          break;
        end
      end
    end
    for (int c = 0; c <= ncyc; c++) exp_q.push_back(exp_vec(c, k, dc, rst_c));
    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("%s c%0d", nm, c), obs_s, e);
      start   = (c == 0) || (c == rs_c);
      if (c == 0) k_len = K_W'(k);
      else if (c == rs_c) k_len = K_W'(rs_k);
      else k_len = K_W'($urandom_range(1, 255));
      sys_rst = (c == rst_c);
      res_val = sched[c];
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    sys_rst = 1'b0;
    res_val = '0;
  endtask

  task automatic std_sched(input int first);
    clear_sched();
    for (int i = 0; i < 4; i++) sched[first + i] = 4'b1111;
  endtask

  initial begin
    clk = 1'b0;
    n_cmp = 0;
    n_err = 0;
    sys_rst = 1'b1;
    start = 1'b1;
    k_len = 8'd3;
    res_val = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs_s, '0);
    sys_rst = 1'b0;
    start = 1'b0;
    res_val = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", obs_s, '0);
    end

    std_sched(5);
    run_job("basic_k3", 3, 11, -1, 0, -1);
    clear_sched();
    run_job("k0", 0, 3, -1, 0, -1);
    std_sched(5);
    run_job("restart_in_run", 3, 11, 2, 7, -1);
    std_sched(5);
    run_job("start_in_done", 3, 12, 9, 5, -1);

    clear_sched();
    sched[0]  = 4'b1111;
    sched[5]  = 4'b0001;
    sched[7]  = 4'b0110;
    sched[8]  = 4'b1000;
    sched[10] = 4'b1111;
    sched[12] = 4'b0011;
    sched[13] = 4'b1111;
    sched[15] = 4'b0101;
    sched[18] = 4'b1111;
    run_job("scatter", 3, 20, -1, 0, -1);
    std_sched(5);
    run_job("after_scatter", 3, 11, -1, 0, -1);

    std_sched(5);
    run_job("k1", 1, 11, -1, 0, -1);
    std_sched(9);
    run_job("k5", 5, 15, -1, 0, -1);

    clear_sched();
    run_job("rst_in_run", 3, 8, -1, 0, 3);
    std_sched(5);
    run_job("fresh_after_rst", 3, 11, -1, 0, -1);
    clear_sched();
    sched[5] = 4'b1111;
    run_job("rst_in_drain", 3, 9, -1, 0, 6);
    std_sched(5);
    run_job("after_drain_rst", 3, 11, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter N, default 4, systolic array dimension (N x N PE_MAC grid).
REQ-002 Parameter K_W, default 8, width of inner-dimension length and buffer address.
REQ-003 Parameter CNT_W, default 8, width of the result counter; SHALL satisfy 2^CNT_W > N*N.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle job request; sampled only in IDLE.
REQ-007 k_len  input  K_W  inner dimension K; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at job completion.
REQ-010 cal_en  output  1  drives top-left PE cal_en.
REQ-011 cal_done  output  1  drives top-left PE cal_done.
REQ-012 a_rd_en  output  N  per-row read enable, west operand buffers.
REQ-013 a_rd_addr  output  N*K_W  per-row read address; row i in bits [i*K_W +: K_W].
REQ-014 b_rd_en  output  N  per-column read enable, north operand buffers.
REQ-015 b_rd_addr  output  N*K_W  per-column read address, same packing.
REQ-016 res_val  input  N  dout_val from the bottom-row PEs, one bit per column.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN on start=1 with k_len!=0; K latched into kreg and cycle counter t cleared to 0.
REQ-019 IDLE->DONE on start=1 with k_len==0; no cal_en, cal_done or rd_en activity.
REQ-020 start outside IDLE SHALL be ignored; k_len changes after latching SHALL have no effect.
REQ-021 RUN lasts exactly kreg+1 cycles (t=0..kreg).
  - cal_en=1 throughout RUN.
  - cal_done=1 only at t==kreg.
  - RUN->DRAIN after t==kreg.
REQ-022 Base read strobe SHALL be high for t in [0, kreg-1] with base address = t.
  - Row/column i strobe and address SHALL equal the base delayed by exactly i cycles (registered shift chain).
  - a_rd_en[i] and b_rd_en[i] are identical in timing, as are their addresses.
  - Deasserted enable implies address 0; buffers return 0 when not enabled, so the PE product at t==kreg is zero.
REQ-023 The skew chain SHALL continue shifting in DRAIN until empty; the last strobe is row N-1 at t = kreg+N-2.
REQ-024 In RUN and DRAIN, the result counter SHALL add popcount(res_val) every cycle.
  - res_val is ignored in IDLE and DONE.
REQ-025 DRAIN->DONE in the cycle after the counter reaches >= N*N.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
  - Counter cleared on DONE->IDLE.
  - start in DONE is ignored.
REQ-027 busy=1 in RUN, DRAIN and DONE.
REQ-028 cal_en, cal_done and all rd_en outputs SHALL be 0 in IDLE, DRAIN and DONE, except the REQ-023 skew tail in DRAIN.
REQ-029 Counter arithmetic is unsigned CNT_W bits and SHALL saturate, not wrap.
REQ-030 Minimum job latency, start to done: kreg+1 (RUN) + DRAIN + 1 cycles.
  - DRAIN length is set by res_val; there is no timeout.

Reset
REQ-031 sys_rst=1 at any clock edge SHALL force IDLE, regardless of current state, including mid-RUN and mid-DRAIN.
  - Counters, kreg and skew chains cleared.
  - busy, done, cal_en, cal_done, a_rd_en, b_rd_en, a_rd_addr and b_rd_addr all 0 the cycle after.
REQ-032 start coincident with sys_rst SHALL be ignored.

Verification
REQ-033 N=4, k_len=3, start at cycle 0 -> cal_en high cycles 1-4, cal_done only at cycle 4; a_rd_en[0] high at cycles 1-3 with addr 0,1,2; a_rd_en[3] high at cycles 4-6 with addr 0,1,2.
REQ-034 Same job; res_val=4'b1111 on four consecutive DRAIN cycles -> done pulses exactly one cycle after the 16th result is counted, busy falls with it, and the next state is IDLE.
REQ-035 start with k_len=0 -> done one cycle later, busy high that single cycle, no cal_en or rd_en pulses.
REQ-036 start pulsed again in RUN with k_len=7 -> ignored; the job completes with K=3 timing unchanged.
REQ-037 sys_rst asserted at t=2 of RUN -> all outputs 0 next cycle; a fresh start after reset release runs a correct full job.
REQ-038 res_val pulses scattered, with gaps and single bits, summing to exactly 16 -> done fires exactly once; spurious res_val in IDLE leaves the counter at 0.
